// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, I/O map and decode helpers for data_memory_mmio
package dmem_pkg;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } funct3_e;

   localparam funct3_e SB = LB;
   localparam funct3_e SH = LH;
   localparam funct3_e SW = LW;

   localparam logic [31:0] IN_OFS     = 32'h0000_0000;
   localparam logic [31:0] OUT_OFS    = 32'h0000_0040;
   localparam logic [31:0] STATUS_OFS = 32'h0000_0080;
   localparam logic [31:0] IRQEN_OFS  = 32'h0000_0084;
   localparam logic [31:0] CYCLE_OFS  = 32'h0000_0088;

   function automatic logic funct3_legal(input logic [2:0] f3, input logic we);
      if (we)
         return f3 inside {3'b000, 3'b001, 3'b010};
      return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         LH, LHU: return a[0];
         LW:      return a != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mmio_in_sync.sv
// rtl/mmio_in_sync.sv - per-port 2-flop synchroniser with a third stage for change detection
module mmio_in_sync #(
   parameter int N_IN = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [32*N_IN-1:0]   i_async,
   output logic [32*N_IN-1:0]   o_sync,
   output logic [N_IN-1:0]      o_change
);

   genvar g;
   generate
      for (g = 0; g < N_IN; g++) begin : g_port
         logic [31:0] r_s1, r_s2, r_s3;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_s1 <= '0;
               r_s2 <= '0;
               r_s3 <= '0;
            end else begin
               r_s1 <= i_async[32*g +: 32];
               r_s2 <= r_s1;
               r_s3 <= r_s2;
            end
         end

         assign o_sync[32*g +: 32] = r_s2;
         assign o_change[g]        = r_s2 != r_s3;
      end
   endgenerate

endmodule

// File: rtl/data_memory_mmio.sv
// rtl/data_memory_mmio.sv - RV32I data RAM plus word-only MMIO block with one-cycle registered response
module data_memory_mmio
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter int          N_IN        = 2,
   parameter int          N_OUT       = 2,
   parameter logic [31:0] IO_BASE     = 32'hFFFF_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_we,
   input  logic [2:0]          req_funct3,
   input  logic [31:0]         req_addr,
   input  logic [31:0]         req_wdata,
   output logic                resp_valid,
   output logic [31:0]         resp_rdata,
   output logic                resp_err,
   input  logic [32*N_IN-1:0]  in_ports,
   output logic [32*N_OUT-1:0] out_ports,
   output logic                irq
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]        r_mem [DEPTH_WORDS];
   logic [31:0]        r_out [N_OUT];
   logic [N_IN-1:0]    r_status, r_irq_en;
   logic [31:0]        r_cycle;
   logic               r_irq, r_resp_valid, r_resp_err;
   logic [31:0]        r_resp_rdata;

   logic [32*N_IN-1:0] w_sync;
   logic [N_IN-1:0]    w_change, w_w1c;
   logic               w_is_io, w_err, w_store_ok, w_ram_we, w_io_we;
   logic [31:0]        w_ofs, w_word, w_shift, w_load_data, w_io_rdata, w_wdata;
   logic [AW-1:0]      w_idx;
   logic [3:0]         w_be;

   mmio_in_sync #(.N_IN(N_IN)) u_in_sync (
      .clk      (clk),
      .rst      (rst),
      .i_async  (in_ports),
      .o_sync   (w_sync),
      .o_change (w_change)
   );

   assign w_is_io    = req_addr >= IO_BASE;
   assign w_ofs      = req_addr - IO_BASE;
   assign w_idx      = req_addr[AW+1:2];
   // The I/O block only understands whole words; anything narrower is an error there.
   assign w_err      = !funct3_legal(req_funct3, req_we) || misaligned(req_funct3, req_addr[1:0])
                       || (w_is_io && req_funct3 != LW);
   assign w_store_ok = req_valid && req_we && !w_err;
   assign w_ram_we   = w_store_ok && !w_is_io;
   assign w_io_we    = w_store_ok && w_is_io;
   assign w_w1c      = (w_io_we && w_ofs == STATUS_OFS) ? req_wdata[N_IN-1:0] : '0;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = req_wdata;
      case (req_funct3)
         SB: begin
            w_be    = 4'b0001 << req_addr[1:0];
            w_wdata = {4{req_wdata[7:0]}};
         end
         SH: begin
            w_be    = 4'b0011 << req_addr[1:0];
            w_wdata = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
   end

   assign w_word  = r_mem[w_idx];
   assign w_shift = w_word >> {req_addr[1:0], 3'b000};

   always_comb begin
      w_load_data = w_word;
      case (req_funct3)
         LB:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
         LH:  w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
         LBU: w_load_data = {24'h0, w_shift[7:0]};
         LHU: w_load_data = {16'h0, w_shift[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      w_io_rdata = '0;
      for (int i = 0; i < N_IN; i++)
         if (w_ofs == IN_OFS + 32'(4*i)) w_io_rdata = w_sync[32*i +: 32];
      for (int j = 0; j < N_OUT; j++)
         if (w_ofs == OUT_OFS + 32'(4*j)) w_io_rdata = r_out[j];
      if (w_ofs == STATUS_OFS) w_io_rdata = 32'(r_status);
      if (w_ofs == IRQEN_OFS)  w_io_rdata = 32'(r_irq_en);
      if (w_ofs == CYCLE_OFS)  w_io_rdata = r_cycle;
   end

   // A fresh change event outranks a same-cycle write-1-to-clear of that bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < N_OUT; j++) r_out[j] <= '0;
         r_status <= '0;
         r_irq_en <= '0;
         r_irq    <= 1'b0;
         r_cycle  <= '0;
      end else begin
         r_cycle  <= r_cycle + 32'd1;
         r_irq    <= |(r_status & r_irq_en);
         r_status <= (r_status & ~w_w1c) | w_change;
         if (w_io_we && w_ofs == IRQEN_OFS) r_irq_en <= req_wdata[N_IN-1:0];
         for (int j = 0; j < N_OUT; j++)
            if (w_io_we && w_ofs == OUT_OFS + 32'(4*j)) r_out[j] <= req_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_resp_valid <= req_valid && (!req_we || w_err);
         r_resp_err   <= req_valid && w_err;
         r_resp_rdata <= (req_valid && !req_we && !w_err) ? (w_is_io ? w_io_rdata : w_load_data) : '0;
      end
   end

   genvar go;
   generate
      for (go = 0; go < N_OUT; go++) begin : g_out
         assign out_ports[32*go +: 32] = r_out[go];
      end
   endgenerate

   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign irq        = r_irq;

endmodule

// File: tb/tb_data_memory_mmio.sv
// tb/tb_data_memory_mmio.sv - vector table, directed MMIO sequences and random RAM traffic vs a byte model
module tb_data_memory_mmio;

   localparam int          DEPTH = 256;
   localparam int          NI    = 2;
   localparam int          NO    = 2;
   localparam logic [31:0] IOB   = 32'hFFFF_0000;

   localparam logic [2:0] F_B = 3'd0, F_H = 3'd1, F_W = 3'd2, F_BU = 3'd4, F_HU = 3'd5;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]     req_funct3 = '0;
   logic [31:0]    req_addr = '0, req_wdata = '0;
   logic           resp_valid, resp_err, irq;
   logic [31:0]    resp_rdata;
   logic [32*NI-1:0] in_ports = '0;
   logic [32*NO-1:0] out_ports;

   always #5 clk = ~clk;

   data_memory_mmio #(.DEPTH_WORDS(DEPTH), .N_IN(NI), .N_OUT(NO), .IO_BASE(IOB)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .in_ports(in_ports), .out_ports(out_ports), .irq(irq)
   );

   int          n_checks = 0, n_fail = 0;
   logic        got_v, got_e;
   logic [31:0] got_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1;
      got_v = resp_valid; got_e = resp_err; got_d = resp_rdata;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   typedef struct packed {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        ev;
      logic        ee;
      logic [31:0] ed;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                               input logic ev, input logic ee, input logic [31:0] ed);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = a; v.wd = wd; v.ev = ev; v.ee = ee; v.ed = ed;
      return v;
   endfunction

   vec_t tbl [31];

   // Byte-level reference model of the RAM (aliasing folds every address into DEPTH*4 bytes).
   byte unsigned mm [DEPTH*4];

   task automatic rand_op(input int k);
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a, wd, val;
      int unsigned size;
      logic        legal, err;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      a    = (32'($urandom_range(0, 15)) << 10) | 32'($urandom_range(0, DEPTH*4-1));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd   = $urandom;
      size = 1 << f3[1:0];
      legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
      err   = !legal || ((a % size) != 0);
      access(we, f3, a, wd);
      if (err) begin
         check($sformatf("rnd%0d.valid", k), 32'(got_v), 32'd1);
         check($sformatf("rnd%0d.err", k), 32'(got_e), 32'd1);
         check($sformatf("rnd%0d.rdata", k), got_d, 32'd0);
      end else if (we) begin
         for (int unsigned b = 0; b < size; b++) mm[(a + b) % (DEPTH*4)] = wd[8*b +: 8];
         check($sformatf("rnd%0d.valid", k), 32'(got_v), 32'd0);
      end else begin
         val = 0;
         for (int unsigned b = 0; b < size; b++) val = val | (32'(mm[(a + b) % (DEPTH*4)]) << (8*b));
         if (f3 < 3'd4 && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
         check($sformatf("rnd%0d.valid", k), 32'(got_v), 32'd1);
         check($sformatf("rnd%0d.err", k), 32'(got_e), 32'd0);
         check($sformatf("rnd%0d.rdata", k), got_d, val);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] c1, c2;

      tbl[0]  = mk(1, F_W,  32'h10, 32'h1234_5678, 0, 0, 0);
      tbl[1]  = mk(0, F_W,  32'h10, 0, 1, 0, 32'h1234_5678);
      tbl[2]  = mk(1, F_B,  32'h13, 32'h0000_00AB, 0, 0, 0);
      tbl[3]  = mk(0, F_B,  32'h13, 0, 1, 0, 32'hFFFF_FFAB);
      tbl[4]  = mk(0, F_BU, 32'h13, 0, 1, 0, 32'h0000_00AB);
      tbl[5]  = mk(0, F_W,  32'h10, 0, 1, 0, 32'hAB34_5678);
      tbl[6]  = mk(0, F_H,  32'h11, 0, 1, 1, 0);
      tbl[7]  = mk(1, F_W,  32'h20, 32'hCAFE_F00D, 0, 0, 0);
      tbl[8]  = mk(1, F_W,  32'h22, 32'h1111_1111, 1, 1, 0);
      tbl[9]  = mk(0, F_W,  32'h20, 0, 1, 0, 32'hCAFE_F00D);
      tbl[10] = mk(0, F_H,  32'h12, 0, 1, 0, 32'hFFFF_AB34);
      tbl[11] = mk(0, F_HU, 32'h12, 0, 1, 0, 32'h0000_AB34);
      tbl[12] = mk(1, F_W,  32'h14, 32'h0, 0, 0, 0);
      tbl[13] = mk(1, F_H,  32'h16, 32'h1234_BEEF, 0, 0, 0);
      tbl[14] = mk(0, F_W,  32'h14, 0, 1, 0, 32'hBEEF_0000);
      tbl[15] = mk(0, F_B,  32'h10, 0, 1, 0, 32'h0000_0078);
      tbl[16] = mk(0, 3'd3, 32'h10, 0, 1, 1, 0);
      tbl[17] = mk(0, 3'd6, 32'h10, 0, 1, 1, 0);
      tbl[18] = mk(1, 3'd4, 32'h10, 32'h55, 1, 1, 0);
      tbl[19] = mk(1, 3'd5, 32'h12, 32'h55, 1, 1, 0);
      tbl[20] = mk(0, F_W,  32'h10 + DEPTH*4, 0, 1, 0, 32'hAB34_5678);
      tbl[21] = mk(0, F_W,  IOB + 32'h100, 0, 1, 0, 0);
      tbl[22] = mk(1, F_W,  IOB + 32'h84, 32'hFFFF_FFFF, 0, 0, 0);
      tbl[23] = mk(0, F_W,  IOB + 32'h84, 0, 1, 0, 32'h3);
      tbl[24] = mk(0, F_HU, IOB + 32'h88, 0, 1, 1, 0);
      tbl[25] = mk(1, F_W,  IOB + 32'h00, 32'hFFFF_FFFF, 0, 0, 0);
      tbl[26] = mk(0, F_W,  IOB + 32'h00, 0, 1, 0, 0);
      tbl[27] = mk(1, F_W,  IOB + 32'h84, 32'h1, 0, 0, 0);
      tbl[28] = mk(0, F_W,  IOB + 32'h84, 0, 1, 0, 32'h1);
      tbl[29] = mk(1, F_W,  IOB + 32'h42, 32'h9, 1, 1, 0);
      tbl[30] = mk(0, F_B,  32'h17, 0, 1, 0, 32'hFFFF_FFBE);

      #1 rst = 1'b1;
      #1;
      check("reset.resp_valid", 32'(resp_valid), 0);
      check("reset.resp_rdata", resp_rdata, 0);
      check("reset.resp_err", 32'(resp_err), 0);
      check("reset.out_ports", out_ports[31:0] | out_ports[63:32], 0);
      check("reset.irq", 32'(irq), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 31; i++) begin
         access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd);
         check($sformatf("vec%0d.valid", i), 32'(got_v), 32'(tbl[i].ev));
         if (tbl[i].ev) begin
            check($sformatf("vec%0d.err", i), 32'(got_e), 32'(tbl[i].ee));
            check($sformatf("vec%0d.rdata", i), got_d, tbl[i].ed);
         end
      end

      access(0, F_W, 32'h10, 0);
      idle(1);
      @(posedge clk); #1;
      check("one_cycle.resp_valid", 32'(resp_valid), 0);

      access(1, F_W, IOB + 32'h44, 32'h0000_DEAD);
      check("out1.port", out_ports[63:32], 32'h0000_DEAD);
      check("out0.port", out_ports[31:0], 0);
      access(0, F_W, IOB + 32'h44, 0);
      check("out1.read", got_d, 32'h0000_DEAD);
      access(1, F_B, IOB + 32'h44, 32'h11);
      check("out1.sb_err", 32'(got_v & got_e), 1);
      access(0, F_W, IOB + 32'h44, 0);
      check("out1.after_sb", got_d, 32'h0000_DEAD);
      idle(1);

      @(negedge clk);
      req_valid = 1'b0;
      in_ports[31:0] = 32'd5;
      access(0, F_W, IOB + 32'h00, 0);
      check("in0.too_early", got_d, 0);
      access(0, F_W, IOB + 32'h00, 0);
      check("in0.synced", got_d, 32'd5);
      idle(1);
      access(0, F_W, IOB + 32'h80, 0);
      check("status.set", got_d, 32'h1);
      check("irq.set", 32'(irq), 1);
      access(1, F_W, IOB + 32'h80, 32'h1);
      check("irq.held_one_cycle", 32'(irq), 1);
      idle(1);
      @(posedge clk); #1;
      check("irq.dropped", 32'(irq), 0);
      access(0, F_W, IOB + 32'h80, 0);
      check("status.cleared", got_d, 0);

      @(negedge clk);
      req_valid = 1'b0;
      in_ports[63:32] = 32'd7;
      idle(1);
      access(1, F_W, IOB + 32'h80, 32'h2);
      access(0, F_W, IOB + 32'h80, 0);
      check("status.set_wins", got_d, 32'h2);
      access(1, F_W, IOB + 32'h80, 32'h2);
      access(0, F_W, IOB + 32'h80, 0);
      check("status.w1c_bit1", got_d, 0);
      check("irq.masked", 32'(irq), 0);

      access(0, F_W, IOB + 32'h88, 0);
      c1 = got_d;
      idle(9);
      access(0, F_W, IOB + 32'h88, 0);
      c2 = got_d;
      check("cycle.delta", c2 - c1, 32'd10);

      for (int w = 0; w < DEPTH; w++) begin
         logic [31:0] d;
         d = $urandom;
         access(1, F_W, 32'(4*w), d);
         for (int b = 0; b < 4; b++) mm[4*w + b] = d[8*b +: 8];
      end
      for (int k = 0; k < 300; k++) rand_op(k);

      access(0, F_W, 32'h10, 0);
      #1 rst = 1'b1;
      #1;
      check("midrst.resp_valid", 32'(resp_valid), 0);
      check("midrst.resp_rdata", resp_rdata, 0);
      check("midrst.resp_err", 32'(resp_err), 0);
      check("midrst.out_ports", out_ports[31:0] | out_ports[63:32], 0);
      check("midrst.irq", 32'(irq), 0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_W; req_addr = IOB + 32'h88;
      @(posedge clk); #1;
      check("midrst.cycle_valid", 32'(resp_valid), 1);
      check("midrst.cycle_zero", resp_rdata, 0);
      idle(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
